// File: rtl/shaft_odometer.sv
// shaft_odometer
//   Wheel-encoder front end for the drive state machine. Each raw encoder
//   input is synchronised, debounced and turned into a one-cycle tick. The
//   ticks feed cumulative distance counters, a windowed speed measurement,
//   a move-by-distance handshake and per-wheel stall detection.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   shaftPulseL/R              raw encoder inputs (asynchronous)
//   clrDist                    synchronous clear of distL/distR
//   moveStart/moveAbort        move handshake controls
//   moveTarget [CNT_W]         ticks to travel per wheel (averaged over L+R)
//   moveBusy/moveDone          move in progress / one-cycle completion pulse
//   distL/distR [CNT_W]        cumulative tick counts (wrapping)
//   rateL/rateR [RATE_W]       ticks in last completed window (saturated)
//   rateValid                  one-cycle pulse when rateL/rateR update
//   stallL/stallR              wheel saw no ticks for STALL_WINDOWS windows in a move
module shaft_odometer #(
    parameter int DEBOUNCE_CYCLES = 5000,
    parameter int WINDOW_CYCLES   = 5_000_000,
    parameter int CNT_W           = 16,
    parameter int RATE_W          = 12,
    parameter int STALL_WINDOWS   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shaftPulseL,
    input  logic              shaftPulseR,
    input  logic              clrDist,
    input  logic              moveStart,
    input  logic              moveAbort,
    input  logic [CNT_W-1:0]  moveTarget,
    output logic              moveBusy,
    output logic              moveDone,
    output logic [CNT_W-1:0]  distL,
    output logic [CNT_W-1:0]  distR,
    output logic [RATE_W-1:0] rateL,
    output logic [RATE_W-1:0] rateR,
    output logic              rateValid,
    output logic              stallL,
    output logic              stallR
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int ZW_W  = $clog2(STALL_WINDOWS + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [ZW_W-1:0]  ZW_LAST  = ZW_W'(STALL_WINDOWS - 1);
    localparam logic [ZW_W-1:0]  ZW_MAX   = ZW_W'(STALL_WINDOWS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    function automatic logic [RATE_W-1:0] f_rate_inc(input logic [RATE_W-1:0] v);
        return (&v) ? v : v + RATE_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] f_prog_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Index 0 = left wheel, index 1 = right wheel throughout.
    logic [1:0]        w_raw;
    logic [1:0]        r_sync1, r_sync2, r_filt, r_filt_d, r_tick;
    logic [DB_W-1:0]   r_db_cnt [2];
    logic [CNT_W-1:0]  r_dist   [2];
    logic [RATE_W-1:0] r_acc    [2];
    logic [RATE_W-1:0] r_rate   [2];
    logic [CNT_W-1:0]  r_prog   [2];
    logic [ZW_W-1:0]   r_zw     [2];
    logic [1:0]        r_stall;
    logic [WIN_W-1:0]  r_win_cnt;
    logic              r_rate_valid;
    logic [CNT_W-1:0]  r_target;
    state_t            r_state, w_next;
    logic              w_busy, w_done;
    logic              w_win_term, w_enter_idle, w_reached, w_accept;
    logic [CNT_W:0]    w_sum, w_goal;

    assign w_raw        = {shaftPulseR, shaftPulseL};
    assign w_win_term   = (r_win_cnt == WIN_LAST);
    assign w_accept     = (r_state == S_IDLE) && moveStart;
    assign w_enter_idle = (w_next == S_IDLE) && (r_state != S_IDLE);
    // Average travel reaches target when L+R >= 2*target; one extra bit avoids overflow.
    assign w_sum        = {1'b0, r_prog[0]} + {1'b0, r_prog[1]};
    assign w_goal       = {r_target, 1'b0};
    assign w_reached    = (w_sum >= w_goal);

    // Stage 1: synchroniser, debounce filter and tick generation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_filt   <= '0;
            r_filt_d <= '0;
            r_tick   <= '0;
            for (int k = 0; k < 2; k++) r_db_cnt[k] <= '0;
        end else begin
            r_sync1  <= w_raw;
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            r_tick   <= r_filt & ~r_filt_d;
            for (int k = 0; k < 2; k++) begin
                // Counter only advances while synced and filtered levels disagree;
                // any agreement restarts the qualification period.
                if (r_sync2[k] != r_filt[k]) begin
                    if (r_db_cnt[k] == DB_LAST) begin
                        r_filt[k]   <= r_sync2[k];
                        r_db_cnt[k] <= '0;
                    end else begin
                        r_db_cnt[k] <= r_db_cnt[k] + DB_W'(1);
                    end
                end else begin
                    r_db_cnt[k] <= '0;
                end
            end
        end
    end

    // Stage 2: distance, rate window, move progress and stall tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt    <= '0;
            r_rate_valid <= 1'b0;
            r_target     <= '0;
            r_stall      <= '0;
            for (int k = 0; k < 2; k++) begin
                r_dist[k] <= '0;
                r_acc[k]  <= '0;
                r_rate[k] <= '0;
                r_prog[k] <= '0;
                r_zw[k]   <= '0;
            end
        end else begin
            r_win_cnt    <= w_win_term ? '0 : r_win_cnt + WIN_W'(1);
            r_rate_valid <= w_win_term;
            if (w_accept) r_target <= moveTarget;
            for (int k = 0; k < 2; k++) begin
                if (clrDist)        r_dist[k] <= '0;
                else if (r_tick[k]) r_dist[k] <= r_dist[k] + CNT_W'(1);

                // A tick in the terminal cycle seeds the next window.
                if (w_win_term) begin
                    r_rate[k] <= r_acc[k];
                    r_acc[k]  <= r_tick[k] ? RATE_W'(1) : '0;
                end else if (r_tick[k]) begin
                    r_acc[k]  <= f_rate_inc(r_acc[k]);
                end

                if (w_accept)                              r_prog[k] <= '0;
                else if ((r_state == S_RUN) && r_tick[k])  r_prog[k] <= f_prog_inc(r_prog[k]);

                if (w_enter_idle || r_tick[k]) begin
                    r_zw[k]    <= '0;
                    r_stall[k] <= 1'b0;
                end else if ((r_state == S_RUN) && w_win_term && (r_acc[k] == '0)) begin
                    if (r_zw[k] != ZW_MAX) r_zw[k] <= r_zw[k] + ZW_W'(1);
                    if (r_zw[k] >= ZW_LAST) r_stall[k] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (moveStart) w_next = (moveTarget == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                w_busy = 1'b1;
                // Abort has priority over a completion seen in the same cycle.
                if (moveAbort)      w_next = S_IDLE;
                else if (w_reached) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign moveBusy  = w_busy;
    assign moveDone  = w_done;
    assign distL     = r_dist[0];
    assign distR     = r_dist[1];
    assign rateL     = r_rate[0];
    assign rateR     = r_rate[1];
    assign rateValid = r_rate_valid;
    assign stallL    = r_stall[0];
    assign stallR    = r_stall[1];

endmodule

// File: tb/tb_shaft_odometer.sv
// Directed bench for shaft_odometer. Expected values are queued before each
// stimulus step and popped when the corresponding DUT output is sampled.
// The window is 200 cycles so that 20 ticks at the fastest debounced pulse
// rate (8 cycles per pulse) fit inside a single window.
module tb_shaft_odometer;

    localparam int DEB  = 4;
    localparam int WIN  = 200;
    localparam int CW   = 8;
    localparam int RW   = 4;
    localparam int STW  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          shaftPulseL, shaftPulseR, clrDist, moveStart, moveAbort;
    logic [CW-1:0] moveTarget;
    logic          moveBusy, moveDone, rateValid, stallL, stallR;
    logic [CW-1:0] distL, distR;
    logic [RW-1:0] rateL, rateR;

    shaft_odometer #(
        .DEBOUNCE_CYCLES(DEB), .WINDOW_CYCLES(WIN), .CNT_W(CW),
        .RATE_W(RW), .STALL_WINDOWS(STW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .shaftPulseL(shaftPulseL), .shaftPulseR(shaftPulseR),
        .clrDist(clrDist), .moveStart(moveStart), .moveAbort(moveAbort),
        .moveTarget(moveTarget), .moveBusy(moveBusy), .moveDone(moveDone),
        .distL(distL), .distR(distR), .rateL(rateL), .rateR(rateR),
        .rateValid(rateValid), .stallL(stallL), .stallR(stallR)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] sb [$];
    int expL = 0;
    int expR = 0;

    // Event monitors
    int   done_cnt = 0, done_cyc = 0, done_wide = 0;
    int   busy_cnt = 0, busy_fall_cyc = 0, rv_wide = 0;
    logic done_prev = 1'b0, busy_prev = 1'b0, rv_prev = 1'b0;
    always @(negedge clk) begin
        if (moveDone === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (done_prev) done_wide++;
        end
        done_prev = (moveDone === 1'b1);
        if (busy_prev && (moveBusy !== 1'b1)) busy_fall_cyc = cyc;
        if (moveBusy === 1'b1) busy_cnt++;
        busy_prev = (moveBusy === 1'b1);
        if ((rateValid === 1'b1) && rv_prev) rv_wide++;
        rv_prev = (rateValid === 1'b1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic [31:0] v);
        sb.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL %s: observed %0d, no expected value queued", tag, obs);
        end else begin
            exp_v = sb.pop_front();
            assert (obs === exp_v) else begin
                n_bad++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
            end
        end
    endtask

    // 4 cycles high / 4 low per pulse: the fastest rate the debouncer passes.
    task automatic pulses(input int nl, input int nr);
        int n;
        n = (nl > nr) ? nl : nr;
        for (int i = 0; i < n; i++) begin
            shaftPulseL = (i < nl);
            shaftPulseR = (i < nr);
            step(4);
            shaftPulseL = 1'b0;
            shaftPulseR = 1'b0;
            step(4);
        end
        expL += nl;
        expR += nr;
    endtask

    task automatic start_move(input logic [CW-1:0] tgt);
        moveTarget = tgt;
        moveStart  = 1'b1;
        step(1);
        moveStart  = 1'b0;
        moveTarget = '0;
    endtask

    task automatic abort_move();
        moveAbort = 1'b1;
        step(1);
        moveAbort = 1'b0;
    endtask

    task automatic wait_rv();
        int k;
        k = 0;
        do begin
            step(1);
            k++;
        end while ((rateValid !== 1'b1) && (k < 2 * WIN + 10));
        if (rateValid !== 1'b1) begin
            n_vec++;
            n_bad++;
            $error("FAIL rate_window_timeout: observed no rateValid, expected one within %0d cycles", k);
        end
    endtask

    int d0, b0, rise;

    initial begin
        rst_n = 1'b0; shaftPulseL = 1'b0; shaftPulseR = 1'b0; clrDist = 1'b0;
        moveStart = 1'b0; moveAbort = 1'b0; moveTarget = '0;
        step(3);
        sb_push(0); check("rst_distL", distL);
        sb_push(0); check("rst_distR", distR);
        sb_push(0); check("rst_rateR", rateR);
        sb_push(0); check("rst_rateValid", rateValid);
        sb_push(0); check("rst_moveBusy", moveBusy);
        sb_push(0); check("rst_moveDone", moveDone);
        sb_push(0); check("rst_stallL", stallL);
        rst_n = 1'b1;
        step(2);

        // Debounce: short glitch rejected, clean pulse ticks 7 cycles after edge
        sb_push(0);
        shaftPulseL = 1'b1; step(3); shaftPulseL = 1'b0; step(10);
        check("glitch_distL", distL);
        sb_push(0); sb_push(1);
        shaftPulseL = 1'b1;
        step(7); check("tick_lat_before", distL);
        step(1); check("tick_lat_at", distL);
        expL = 1;
        step(2); shaftPulseL = 1'b0; step(8);

        // Move target 5 with 5 tick pairs
        d0 = done_cnt;
        start_move(8'd5);
        sb_push(1); check("move_busy", moveBusy);
        pulses(4, 4);
        sb_push(0); check("move_no_early_done", done_cnt - d0);
        rise = cyc;
        shaftPulseL = 1'b1; shaftPulseR = 1'b1; step(4);
        shaftPulseL = 1'b0; shaftPulseR = 1'b0; step(8);
        expL++; expR++;
        sb_push(1); check("move_done_count", done_cnt - d0);
        sb_push(9); check("move_done_latency", done_cyc - rise);
        sb_push(9); check("move_busy_fall", busy_fall_cyc - rise);
        sb_push(expL & 255); check("move_distL", distL);
        sb_push(expR & 255); check("move_distR", distR);

        // Unequal wheels L=7 R=3 still complete
        d0 = done_cnt;
        start_move(8'd5);
        pulses(6, 3); step(3);
        sb_push(0); check("move73_partial_done", done_cnt - d0);
        sb_push(1); check("move73_partial_busy", moveBusy);
        pulses(1, 0); step(3);
        sb_push(1); check("move73_done", done_cnt - d0);
        sb_push(0); check("move73_busy_after", moveBusy);

        // L=4 R=5 is short of 10
        d0 = done_cnt;
        start_move(8'd5);
        pulses(4, 5); step(3);
        sb_push(0); check("move45_no_done", done_cnt - d0);
        sb_push(1); check("move45_busy", moveBusy);
        abort_move();
        sb_push(0); check("move45_abort_busy", moveBusy);

        // Zero target completes immediately without RUN
        d0 = done_cnt; b0 = busy_cnt;
        start_move(8'd0);
        sb_push(1); check("zero_done_next", moveDone);
        step(1);
        sb_push(0); check("zero_done_single", moveDone);
        step(2);
        sb_push(1); check("zero_done_count", done_cnt - d0);
        sb_push(0); check("zero_busy_never", busy_cnt - b0);

        // Abort discards progress; moveStart during RUN ignored
        d0 = done_cnt;
        start_move(8'd20);
        pulses(3, 0);
        abort_move();
        sb_push(0); check("abort_busy", moveBusy);
        step(3);
        sb_push(0); check("abort_no_done", done_cnt - d0);
        start_move(8'd2);
        start_move(8'd0);
        pulses(1, 2); step(3);
        sb_push(0); check("restart_no_early_done", done_cnt - d0);
        sb_push(1); check("restart_busy", moveBusy);
        pulses(1, 0); step(3);
        sb_push(1); check("restart_done", done_cnt - d0);

        // Rate window: saturation, then a tick on the terminal cycle
        wait_rv();
        pulses(0, 20);
        sb_push(15); sb_push(0);
        wait_rv();
        check("rate_sat_R", rateR);
        check("rate_idle_L", rateL);
        step(1);
        sb_push(0); check("rate_valid_single", rateValid);
        sb_push(expR & 255); check("rate_distR", distR);
        step(191);
        shaftPulseR = 1'b1; step(4); shaftPulseR = 1'b0; step(3);
        expR++;
        sb_push(0); wait_rv(); check("rate_term_old_window", rateR);
        sb_push(1); wait_rv(); check("rate_term_new_window", rateR);

        // Stall: right wheel idle for two windows during a move
        wait_rv();
        start_move(8'd50);
        pulses(2, 0);
        wait_rv();
        sb_push(0); check("stall_R_one_window", stallR);
        sb_push(0); check("stall_L_one_window", stallL);
        pulses(2, 0);
        wait_rv();
        sb_push(1); check("stall_R_set", stallR);
        sb_push(0); check("stall_L_clear", stallL);
        sb_push(1); check("stall_busy", moveBusy);
        shaftPulseR = 1'b1; step(4); shaftPulseR = 1'b0; step(3);
        expR++;
        sb_push(1); check("stall_R_hold", stallR);
        step(1);
        sb_push(0); check("stall_R_tick_clear", stallR);
        abort_move();
        sb_push(0); check("stall_abort_busy", moveBusy);

        // Distance wrap and clear
        clrDist = 1'b1; step(1); clrDist = 1'b0;
        expL = 0; expR = 0;
        sb_push(0); check("clr_distL", distL);
        sb_push(0); check("clr_distR", distR);
        pulses(255, 0); step(2);
        sb_push(expL & 255); check("wrap_distL_255", distL);
        pulses(1, 0); step(2);
        sb_push(expL & 255); check("wrap_distL_0", distL);
        shaftPulseL = 1'b1; step(4); shaftPulseL = 1'b0; step(3);
        clrDist = 1'b1; step(1); clrDist = 1'b0;
        expL = 0; expR = 0;
        sb_push(0); check("clr_tick_coincident", distL);
        step(4);
        sb_push(0); check("clr_tick_after", distL);

        // Reset during a move
        d0 = done_cnt;
        start_move(8'd20);
        pulses(1, 1);
        rst_n = 1'b0;
        #1;
        sb_push(0); check("midrst_distL", distL);
        sb_push(0); check("midrst_distR", distR);
        sb_push(0); check("midrst_busy", moveBusy);
        sb_push(0); check("midrst_rateR", rateR);
        @(posedge clk); #1;
        rst_n = 1'b1;
        expL = 0; expR = 0;
        step(20);
        sb_push(0); check("midrst_no_done", done_cnt - d0);
        sb_push(0); check("midrst_busy_after", moveBusy);

        sb_push(0); check("done_pulse_width", done_wide);
        sb_push(0); check("rv_pulse_width", rv_wide);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
